fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the core. Holds the PC, issues in-order word requests to instruction memory, buffers returned words in a 2-entry queue, and presents them to decode with a valid/ready handshake. The output splits each word into `dec_opcode` (bits 6:0) and `dec_instruction` (bits 31:7, 25 bits). This is the opcode-stripped form consumed by decode and immediate sign extension. Branch/jump redirects flush the queue and discard stale in-flight responses.

## Interface
- `DATA_WIDTH`, 32: PC/address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `QUEUE_DEPTH`, 2: fetch queue entries; also the cap on buffered + outstanding requests.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  DATA_WIDTH  word address (current PC).
- `imem_rsp_valid`  in  1  response valid; in order, at least 1 cycle after acceptance, never back-pressured.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  redirect from execute.
- `redirect_pc`  in  DATA_WIDTH  redirect target.
- `dec_valid`  out  1  queue head valid.
- `dec_ready`  in  1  decode consumes head.
- `dec_pc`  out  DATA_WIDTH  PC of head word.
- `dec_opcode`  out  7  head word [6:0].
- `dec_instruction`  out  25  head word [31:7].
- `bubble_count`  out  32  present only with `FETCH_BUBBLE_CNT_EN`.

## Operation
- State: `pc`, `inflight` (0..QUEUE_DEPTH), `drop` (0..QUEUE_DEPTH), and a circular queue of {pc, word} with head/tail pointers and a count.
- A request fires when `imem_req_valid && imem_req_ready`. On fire, `pc <= pc + 4` (wraps modulo 2^DATA_WIDTH) and `inflight` increments.
- `imem_req_valid = !redirect_valid && (count + inflight - deq) < QUEUE_DEPTH`, where `deq = dec_valid && dec_ready`. A same-cycle dequeue frees a slot combinationally.
- `imem_req_addr = pc`. The address is held stable while valid and not ready.
- Each request's PC is tracked in order with its response, using a small tag FIFO of depth QUEUE_DEPTH.
- On a response, `inflight` decrements.
  - If `drop > 0`: the response is discarded and `drop` decrements.
  - Otherwise {pc, word} is enqueued.
- Enqueue into a full queue cannot occur; the credit rule prevents it.
- On `redirect_valid`:
  - `pc <= redirect_pc` and the queue is flushed (count 0).
  - `drop <=` outstanding requests not yet returned, counting a request firing this cycle as zero (none fires) and excluding a response arriving this cycle, which is itself discarded.
  - `dec_valid` deasserts the next cycle.
- Redirect has priority over dequeue and enqueue in the same cycle.
- Dequeue and enqueue in the same cycle: count unchanged, both pointers advance.
- `dec_*` outputs come directly from the queue head register (no combinational path from `imem_rsp_*`).

## Timing
- Reset values:
  - `pc = RESET_PC`; `inflight`, `drop`, count and pointers = 0.
  - `imem_req_valid = 1` (with `imem_req_addr = RESET_PC`) is asserted in the first cycle after reset deassertion.
  - `dec_valid = 0`; `dec_pc`, `dec_opcode`, `dec_instruction` = 0; `bubble_count = 0`.
- Latency: response in cycle N → `dec_valid` in cycle N+1.
- Redirect in cycle N → request to `redirect_pc` in cycle N+1.
- Throughput: one instruction per cycle with 1-cycle memory and `dec_ready` held high.
- Reset asserted mid-operation clears all state immediately. Memory responses arriving while in reset or after release for pre-reset requests are the memory's responsibility and must not occur.

## Configuration
- `FETCH_BUBBLE_CNT_EN` defined: `bubble_count` increments (wrapping) every cycle with `dec_ready && !dec_valid`. It is cleared by reset only.
- `FETCH_BUBBLE_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, 1-cycle memory returning `32'h00A0_0093`, `dec_ready=1`:
  - requests at 0x0, 0x4, 0x8 in consecutive cycles;
  - first `dec_valid` with `dec_pc=0`, `dec_opcode=7'h13`, `dec_instruction=25'h0014001`;
  - one instruction per cycle thereafter.
- `dec_ready=0`: after 2 accepted requests, `imem_req_valid` stays 0. Raising `dec_ready` for 1 cycle yields exactly one new request.
- `imem_req_ready=0` for 3 cycles: `imem_req_addr` is held at 0x4 and `pc` does not advance.
- Memory with 3-cycle latency, 2 requests outstanding, redirect to 0x100: both stale responses are dropped, and the next `dec_pc=0x100`.
- Redirect in the same cycle as a response and a dequeue: the response is dropped, the queue is empty the next cycle, and the request to the target is issued the next cycle.
- Async `rst_n` pulse mid-stream: outputs return to reset values without a clock edge. The fetch restarts at RESET_PC. With `FETCH_BUBBLE_CNT_EN`, `bubble_count` reads 0 and then counts stall cycles exactly.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, in-order imem requests, a small
// tag FIFO pairing responses with their PC, and a circular fetch queue that
// feeds decode over a valid/ready handshake.
// Optional feature macro: FETCH_BUBBLE_CNT_EN adds the bubble_count port,
// which counts cycles where decode is ready but no instruction is valid.
module fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_pc,
  output logic [6:0]            dec_opcode,
  output logic [24:0]           dec_instruction
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]           bubble_count
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] pc;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      drop;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      head, tail;
  logic [PTR_W-1:0]      tag_head, tag_tail;
  logic [DATA_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
  logic [31:0]           q_word [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] tag_pc [QUEUE_DEPTH];

  logic           fire;
  logic           deq;
  logic           enq;
  logic [CNT_W:0] credit_used;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check: buffered + outstanding, minus a slot freed by this cycle's dequeue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    credit_used    = '0;
    credit_used    = {1'b0, count} + {1'b0, inflight} - {{CNT_W{1'b0}}, deq};
    imem_req_valid = !redirect_valid && (credit_used < (CNT_W + 1)'(QUEUE_DEPTH));
  end

  assign imem_req_addr   = pc;
  assign fire            = imem_req_valid && imem_req_ready;
  assign dec_valid       = (count != '0);
  assign deq             = dec_valid && dec_ready;
  // A response is buffered only if it is not stale and no redirect is flushing.
  assign enq             = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign dec_pc          = q_pc[head];
  assign dec_opcode      = q_word[head][6:0];
  assign dec_instruction = q_word[head][31:7];

  // PC, outstanding-request count and stale-response drop count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CNT_W'(fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        pc   <= redirect_pc;
        // Everything still out (minus the one returning now) comes back stale.
        drop <= inflight - CNT_W'(imem_rsp_valid);
      end else begin
        if (fire)
          pc <= pc + DATA_WIDTH'(4);
        if (imem_rsp_valid && (drop != '0))
          drop <= drop - 1'b1;
      end
    end
  end

  // Tag FIFO: PC of each outstanding request, popped in order by responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_head <= '0;
      tag_tail <= '0;
    end else begin
      if (fire)
        tag_tail <= next_ptr(tag_tail);
      if (imem_rsp_valid)
        tag_head <= next_ptr(tag_head);
    end
  end

  // Tag storage: written on each accepted request.
  always_ff @(posedge clk) begin
    // NOTE: tag storage has no reset; an entry is always written before a response reads it.
    if (fire)
      tag_pc[tag_tail] <= pc;
  end

  // Fetch queue; storage is cleared too so the decode outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_word[i] <= '0;
      end
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        q_pc[tail]   <= tag_pc[tag_head];
        q_word[tail] <= imem_rsp_data;
        tail         <= next_ptr(tail);
      end
      if (deq)
        head <= next_ptr(head);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

`ifdef FETCH_BUBBLE_CNT_EN
  // Bubble counter: decode ready with nothing to offer; wraps, cleared by reset only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_count <= '0;
    else if (dec_ready && !dec_valid)
      bubble_count <= bubble_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: an instruction memory model with configurable
// latency plus a reference model of the in-order instruction stream that
// decode must observe, checked every cycle, and directed scenario tasks.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic [24:0] dec_instruction;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_count;
`endif

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RESET_PC), .QUEUE_DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_pc          (dec_pc),
    .dec_opcode      (dec_opcode),
    .dec_instruction (dec_instruction)
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    .bubble_count    (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory model and reference stream.
  req_t        pipe[$];
  ent_t        exp_q[$];
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] exp_bubble = '0;
  logic [31:0] rsp_pc_cur = '0;
  bit          rsp_stale_cur = 0;
  bit          mem_fixed = 1;
  int          lat_min = 1;
  int          lat_max = 1;

  // Values sampled in the most recently completed cycle.
  logic        s_req_valid, s_fire, s_dec_valid;
  logic [31:0] s_req_addr, s_dec_pc;
  logic [6:0]  s_dec_op;
  logic [24:0] s_dec_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (mem_fixed) return 32'h00A0_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic clear_model();
    pipe.delete();
    exp_q.delete();
    exp_req_pc    = RESET_PC;
    exp_bubble    = '0;
    rsp_stale_cur = 0;
  endtask

  // One clock cycle: sample at negedge, check against the model, advance it,
  // then after the rising edge present the memory's response for the next cycle.
  task automatic tick();
    bit   deq;
    bit   exp_rv;
    int   outstanding;
    int   lat;
    int   due;
    req_t r;
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_fire      = imem_req_valid && imem_req_ready;
    s_dec_valid = dec_valid;
    s_dec_pc    = dec_pc;
    s_dec_op    = dec_opcode;
    s_dec_ins   = dec_instruction;
    deq = s_dec_valid && dec_ready;

    checks++;
    if (s_dec_valid !== (exp_q.size() > 0)) begin
      errors++;
      $display("FAIL dec_valid cyc=%0d got=%b want=%b", cyc, s_dec_valid, exp_q.size() > 0);
    end
    if (exp_q.size() > 0) begin
      checks++;
      if (s_dec_pc !== exp_q[0].pc || {s_dec_ins, s_dec_op} !== exp_q[0].word) begin
        errors++;
        $display("FAIL dec_head cyc=%0d got pc=%h word=%h want pc=%h word=%h",
                 cyc, s_dec_pc, {s_dec_ins, s_dec_op}, exp_q[0].pc, exp_q[0].word);
      end
    end

    outstanding = pipe.size() + (imem_rsp_valid ? 1 : 0);
    exp_rv = !redirect_valid && ((exp_q.size() + outstanding - (deq ? 1 : 0)) < 2);
    checks++;
    if (s_req_valid !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, s_req_valid, exp_rv);
    end

    if (s_fire) begin
      checks++;
      if (s_req_addr !== exp_req_pc) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, s_req_addr, exp_req_pc);
      end
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (pipe.size() > 0 && due <= pipe[$].due) due = pipe[$].due + 1;
      r.addr = s_req_addr; r.due = due; r.stale = 0;
      pipe.push_back(r);
      exp_req_pc = exp_req_pc + 32'd4;
    end

`ifdef FETCH_BUBBLE_CNT_EN
    checks++;
    if (bubble_count !== exp_bubble) begin
      errors++;
      $display("FAIL bubble_count cyc=%0d got=%0d want=%0d", cyc, bubble_count, exp_bubble);
    end
`endif
    if (dec_ready && !s_dec_valid) exp_bubble = exp_bubble + 32'd1;

    if (redirect_valid) begin
      exp_q.delete();
      foreach (pipe[i]) pipe[i].stale = 1;
      exp_req_pc = redirect_pc;
    end else begin
      if (deq) void'(exp_q.pop_front());
      if (imem_rsp_valid && !rsp_stale_cur)
        exp_q.push_back('{pc: rsp_pc_cur, word: imem_rsp_data});
    end

    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      r = pipe.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(r.addr);
      rsp_pc_cur     = r.addr;
      rsp_stale_cur  = r.stale;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_opcode !== 7'h0 || dec_instruction !== 25'h0) begin
      errors++;
      $display("FAIL %s_dec got v=%b pc=%h op=%h ins=%h want all zero",
               tag, dec_valid, dec_pc, dec_opcode, dec_instruction);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL %s_req got v=%b addr=%h want v=1 addr=%h", tag, imem_req_valid, imem_req_addr, RESET_PC);
    end
`ifdef FETCH_BUBBLE_CNT_EN
    checks++;
    if (bubble_count !== 32'h0) begin
      errors++;
      $display("FAIL %s_bubble got=%0d want=0", tag, bubble_count);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
  endtask

  task automatic test_basic_stream();
    int first;
    mem_fixed = 1; lat_min = 1; lat_max = 1;
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    apply_reset();
    first = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 3) begin
        checks++;
        if (s_fire !== 1'b1 || s_req_addr !== 32'(i * 4)) begin
          errors++;
          $display("FAIL basic_req%0d got fire=%b addr=%h want fire=1 addr=%h", i, s_fire, s_req_addr, i * 4);
        end
      end
      if (first < 0 && s_dec_valid) begin
        first = i;
        checks++;
        if (s_dec_pc !== 32'h0 || s_dec_op !== 7'h13 || s_dec_ins !== 25'h0014001) begin
          errors++;
          $display("FAIL basic_first got pc=%h op=%h ins=%h want pc=0 op=13 ins=0014001",
                   s_dec_pc, s_dec_op, s_dec_ins);
        end
      end else if (first >= 0) begin
        checks++;
        if (s_dec_valid !== 1'b1 || s_dec_pc !== 32'((i - first) * 4)) begin
          errors++;
          $display("FAIL basic_thru cyc=%0d got v=%b pc=%h want v=1 pc=%h", i, s_dec_valid, s_dec_pc, (i - first) * 4);
        end
      end
    end
    checks++;
    if (first != 2) begin
      errors++;
      $display("FAIL basic_latency got first_valid_cycle=%0d want=2", first);
    end
  endtask

  task automatic test_decode_stall();
    int fires;
    mem_fixed = 0; lat_min = 1; lat_max = 1;
    dec_ready = 1'b0; imem_req_ready = 1'b1;
    apply_reset();
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_fire) fires++;
    end
    checks++;
    if (fires != 2 || s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_cap got fires=%0d req_valid=%b want fires=2 req_valid=0", fires, s_req_valid);
    end
    dec_ready = 1'b1;
    tick();
    fires = s_fire ? 1 : 0;
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_fire) fires++;
    end
    checks++;
    if (fires != 1) begin
      errors++;
      $display("FAIL stall_one_slot got fires=%0d want=1", fires);
    end
  endtask

  task automatic test_req_backpressure();
    mem_fixed = 0; lat_min = 1; lat_max = 1;
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    apply_reset();
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h4) begin
        errors++;
        $display("FAIL hold_addr%0d got v=%b addr=%h want v=1 addr=00000004", i, s_req_valid, s_req_addr);
      end
    end
    imem_req_ready = 1'b1;
    tick();
    checks++;
    if (s_fire !== 1'b1 || s_req_addr !== 32'h4) begin
      errors++;
      $display("FAIL hold_release got fire=%b addr=%h want fire=1 addr=00000004", s_fire, s_req_addr);
    end
  endtask

  task automatic test_redirect_slow_mem();
    bit got_req, got_dec;
    mem_fixed = 0; lat_min = 3; lat_max = 3;
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    apply_reset();
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    checks++;
    if (s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_req_gate got=%b want=0", s_req_valid);
    end
    got_req = 0; got_dec = 0;
    for (int i = 0; i < 20 && !got_dec; i++) begin
      tick();
      if (s_fire && !got_req) begin
        got_req = 1;
        checks++;
        if (s_req_addr !== 32'h100) begin
          errors++;
          $display("FAIL redir_first_req got=%h want=00000100", s_req_addr);
        end
      end
      if (s_dec_valid) begin
        got_dec = 1;
        checks++;
        if (s_dec_pc !== 32'h100) begin
          errors++;
          $display("FAIL redir_first_dec got=%h want=00000100", s_dec_pc);
        end
      end
    end
    checks++;
    if (!got_dec) begin
      errors++;
      $display("FAIL redir_timeout got no dec_valid within 20 cycles want one");
    end
  endtask

  task automatic test_redirect_collision();
    bit found;
    mem_fixed = 0; lat_min = 1; lat_max = 1;
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    apply_reset();
    repeat (4) tick();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_rsp_valid && dec_valid) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL coll_setup got no rsp+dec cycle want one");
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    checks++;
    if (s_req_valid !== 1'b0 || s_dec_valid !== 1'b1) begin
      errors++;
      $display("FAIL coll_cycle got req_v=%b dec_v=%b want req_v=0 dec_v=1", s_req_valid, s_dec_valid);
    end
    tick();
    checks++;
    if (s_dec_valid !== 1'b0 || s_fire !== 1'b1 || s_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL coll_next got dec_v=%b fire=%b addr=%h want dec_v=0 fire=1 addr=00000200",
               s_dec_valid, s_fire, s_req_addr);
    end
    repeat (4) tick();
  endtask

  task automatic test_pc_wrap();
    logic [31:0] seen[$];
    mem_fixed = 0; lat_min = 1; lat_max = 1;
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    apply_reset();
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    for (int i = 0; i < 10 && seen.size() < 3; i++) begin
      tick();
      if (s_fire) seen.push_back(s_req_addr);
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'hFFFF_FFF8 || seen[1] !== 32'hFFFF_FFFC || seen[2] !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap got %0d requests first=%h want fffffff8,fffffffc,00000000",
               seen.size(), (seen.size() > 0) ? seen[0] : 32'hx);
    end
    repeat (4) tick();
  endtask

  task automatic test_random();
    mem_fixed = 0; lat_min = 1; lat_max = 3;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      dec_ready      = ($urandom % 4) != 0;
      imem_req_ready = ($urandom % 3) != 0;
      if (($urandom % 20) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    mem_fixed = 0; lat_min = 2; lat_max = 2;
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    apply_reset();
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    tick();
    checks++;
    if (s_fire !== 1'b1 || s_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL async_restart got fire=%b addr=%h want fire=1 addr=%h", s_fire, s_req_addr, RESET_PC);
    end
    for (int i = 0; i < 30; i++) begin
      dec_ready = ($urandom % 2) != 0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_decode_stall();
    test_req_backpressure();
    test_redirect_slow_mem();
    test_redirect_collision();
    test_pc_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
